seg_frame_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display between several frame producers, for example the error countdown, the bonus cycle readout, the mode banner and the input counter.
- Selects one 64-bit frame with fixed priority and enforces a minimum on-screen dwell time, so short-lived messages stay readable.
- Feeds the segment scan driver.
- Frame layout: byte k is digit k, digit 7 is leftmost; each byte is an active-high segment code {dp,g,f,e,d,c,b,a}.

---
 rtl/seg_frame_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_seg_frame_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_frame_arbiter.sv
// Fixed-priority arbiter sharing the 8-digit seven-segment frame between producers, with minimum dwell.
// Optional blinking of requester 0 (alarm) enabled by defining SEG_FRAME_ARB_BLINK_EN.
module seg_frame_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MIN_DWELL_MS = 500,
  parameter int unsigned BLINK_MS     = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_1ms,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*64-1:0]   req_frame,
  input  logic [63:0]             default_frame,
  output logic [63:0]             frame_out,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    hold_active,
  output logic                    switch_pulse
);

  localparam int unsigned FW = 64;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DW = (MIN_DWELL_MS > 0) ? $clog2(MIN_DWELL_MS + 1) : 1;

  if (NUM_REQ < 1 || BLINK_MS < 1) begin : g_param_check
    $error("seg_frame_arbiter: NUM_REQ and BLINK_MS must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   dwell_q, dwell_d, dwell_dec;
  logic [FW-1:0]   frame_q, frame_d;
  logic [NUM_REQ-1:0] grant_d, hi_mask;
  logic            hold_d, pulse_d;
  logic            any_req, hp_any, do_grant, do_idle;
  logic [IW-1:0]   top_idx;
  logic [FW-1:0]   frames [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign frames[i] = req_frame[FW*i +: FW];
  end

  // Lowest set index wins; hi_mask marks requesters that outrank the current owner
  always_comb begin
    top_idx = '0;
    hi_mask = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) top_idx = IW'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i < int'(owner_q));
    end
  end

  assign any_req   = |req_valid;
  assign hp_any    = |(req_valid & hi_mask);
  assign dwell_dec = (tick_1ms && dwell_q != '0) ? dwell_q - DW'(1) : dwell_q;

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant;
    dwell_d  = dwell_q;
    frame_d  = frame_q;
    hold_d   = 1'b0;
    pulse_d  = 1'b0;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    case (state_q)
      IDLE: begin
        frame_d = default_frame;
        if (any_req) do_grant = 1'b1;
      end
      SHOW: begin
        frame_d = frames[owner_q];
        if (hp_any) begin
          do_grant = 1'b1;
        end else if (req_valid[owner_q]) begin
          dwell_d = dwell_dec;
        end else if (dwell_q != '0) begin
          state_d = HOLD;
          hold_d  = 1'b1;
          dwell_d = dwell_dec;
          frame_d = frame_q;
        end else if (any_req) begin
          do_grant = 1'b1;
        end else begin
          do_idle = 1'b1;
        end
      end
      HOLD: begin
        if (hp_any) begin
          do_grant = 1'b1;
        end else if (req_valid[owner_q]) begin
          state_d = SHOW;
          frame_d = frames[owner_q];
          dwell_d = dwell_dec;
        end else if (dwell_q == '0) begin
          if (any_req) do_grant = 1'b1;
          else         do_idle  = 1'b1;
        end else begin
          hold_d  = 1'b1;
          dwell_d = dwell_dec;
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d = SHOW;
      owner_d = top_idx;
      grant_d = NUM_REQ'(1) << top_idx;
      dwell_d = DW'(MIN_DWELL_MS);
      frame_d = frames[top_idx];
      hold_d  = 1'b0;
      pulse_d = 1'b1;
    end else if (do_idle) begin
      state_d = IDLE;
      owner_d = '0;
      grant_d = '0;
      dwell_d = '0;
      frame_d = default_frame;
      hold_d  = 1'b0;
      pulse_d = 1'b1;
    end
  end

`ifdef SEG_FRAME_ARB_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_MS + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Half-period counter for requester 0; restarts "on" whenever ownership changes
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (grant_d != grant) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (grant[0] && tick_1ms) begin
      if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      frame_out   <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      frame_out   <= (grant_d[0] && !phase_d) ? '0 : frame_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) frame_out <= '0;
    else     frame_out <= frame_d;
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      dwell_q      <= '0;
      frame_q      <= '0;
      grant        <= '0;
      hold_active  <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      dwell_q      <= dwell_d;
      frame_q      <= frame_d;
      grant        <= grant_d;
      hold_active  <= hold_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_seg_frame_arbiter.sv
// Directed bench for seg_frame_arbiter with MIN_DWELL_MS=3, BLINK_MS=2.
module tb_seg_frame_arbiter;

  localparam int unsigned NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tick_1ms;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_frame;
  logic [63:0]           default_frame;
  logic [63:0]           frame_out;
  logic [NUM_REQ-1:0]    grant;
  logic                  hold_active;
  logic                  switch_pulse;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] DEF = 64'h3F06_5B4F_666D_7D07;
  localparam logic [63:0] F0  = 64'h7950_505C_5000_0000;
  localparam logic [63:0] F1  = 64'h0000_0000_0000_3F06;
  localparam logic [63:0] F2  = 64'h7C3F_5437_3E6D_0000;
  localparam logic [63:0] F2B = 64'h7C3F_5437_3E6D_4F4F;
  localparam logic [63:0] F3  = 64'h0606_0606_5B5B_5B5B;
  localparam logic [63:0] FE  = 64'h7950_5000_0000_0079;

  seg_frame_arbiter #(.NUM_REQ(NUM_REQ), .MIN_DWELL_MS(3), .BLINK_MS(2)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .req_valid(req_valid),
    .req_frame(req_frame), .default_frame(default_frame), .frame_out(frame_out),
    .grant(grant), .hold_active(hold_active), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [63:0] f,
                           input logic h, input logic p);
    check({tag, ".grant"}, 64'(grant), 64'(g));
    check({tag, ".frame"}, frame_out, f);
    check({tag, ".hold"},  64'(hold_active), 64'(h));
    check({tag, ".pulse"}, 64'(switch_pulse), 64'(p));
  endtask

  initial begin
    rst = 1'b1; tick_1ms = 1'b0; req_valid = '0; req_frame = '0; default_frame = DEF;
    req_frame[64*0 +: 64] = F0;
    req_frame[64*1 +: 64] = F1;
    req_frame[64*2 +: 64] = F2;
    req_frame[64*3 +: 64] = F3;

    // Reset, then idle shows the default frame
    step();
    check_out("rst1", 4'b0000, 64'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_out("idle", 4'b0000, DEF, 1'b0, 1'b0);

    // Single request, drop after one tick, hold for remaining dwell
    req_valid = 4'b0100;
    step();
    check_out("req2", 4'b0100, F2, 1'b0, 1'b1);
    tick();
    check_out("req2.show", 4'b0100, F2, 1'b0, 1'b0);
    req_valid = 4'b0000;
    req_frame[64*2 +: 64] = F2B;
    step();
    check_out("hold.enter", 4'b0100, F2, 1'b1, 1'b0);
    tick();
    check_out("hold.t1", 4'b0100, F2, 1'b1, 1'b0);
    tick();
    check_out("hold.t2", 4'b0100, F2, 1'b1, 1'b0);
    step();
    check_out("hold.idle", 4'b0000, DEF, 1'b0, 1'b1);

    // Preemption of requester 2 by requester 0
    req_valid = 4'b0100;
    step();
    check_out("pre.own2", 4'b0100, F2B, 1'b0, 1'b1);
    req_valid = 4'b0101;
    step();
    check_out("pre.own0", 4'b0001, F0, 1'b0, 1'b1);
    req_valid = 4'b0100;
    step();
    check_out("pre.hold0", 4'b0001, F0, 1'b1, 1'b0);
    tick(); tick(); tick();
    check_out("pre.hold3", 4'b0001, F0, 1'b1, 1'b0);
    step();
    check_out("pre.regrant2", 4'b0100, F2B, 1'b0, 1'b1);

    // Lower priority never preempts an expired owner
    req_valid = 4'b0010;
    step();
    check_out("lp.own1", 4'b0010, F1, 1'b0, 1'b1);
    tick(); tick(); tick();
    req_valid = 4'b1010;
    for (int i = 0; i < 6; i++) step();
    check_out("lp.stay1", 4'b0010, F1, 1'b0, 1'b0);
    req_valid = 4'b1000;
    step();
    check_out("lp.own3", 4'b1000, F3, 1'b0, 1'b1);

    // Tick and preemption in the same cycle while requester 1 holds with dwell=1
    req_valid = 4'b0010;
    step();
    tick(); tick();
    req_valid = 4'b0000;
    step();
    check_out("sim.hold1", 4'b0010, F1, 1'b1, 1'b0);
    tick_1ms = 1'b1; req_valid = 4'b0001;
    step();
    tick_1ms = 1'b0;
    check_out("sim.own0", 4'b0001, F0, 1'b0, 1'b1);
    req_valid = 4'b0000;
    step();
    tick(); tick();
    check_out("sim.reload", 4'b0001, F0, 1'b1, 1'b0);
    tick();
    step();
    check_out("sim.idle", 4'b0000, DEF, 1'b0, 1'b1);

    // Blink of requester 0 (constant frame without the feature)
    req_frame[64*0 +: 64] = FE;
    req_valid = 4'b0001;
    step();
    check_out("blk.grant", 4'b0001, FE, 1'b0, 1'b1);
    tick();
    check("blk.t1", frame_out, FE);
    tick();
`ifdef SEG_FRAME_ARB_BLINK_EN
    check("blk.t2", frame_out, 64'h0);
    tick();
    check("blk.t3", frame_out, 64'h0);
`else
    check("blk.t2", frame_out, FE);
    tick();
    check("blk.t3", frame_out, FE);
`endif
    tick();
    check("blk.t4", frame_out, FE);

    // Reset mid-operation discards the owner
    rst = 1'b1;
    step();
    check_out("mrst", 4'b0000, 64'h0, 1'b0, 1'b0);
    rst = 1'b0; req_valid = 4'b0000;
    step();
    check_out("mrst.idle", 4'b0000, DEF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
